// File: rtl/pe_row_acc.sv
// pe_row_acc
// LANES-wide signed multiply-accumulate row for the MAC array. It sits between
// the operand feeders and the psum collector. Every group of cfg_len input
// beats (0 counts as 1) produces exactly one scaled, saturated output word.
//
// Pipeline: S0 input capture -> S1 lane products -> S2 lane sum ->
// S3 accumulate / shift / clamp into the output register. The last beat of a
// group is accepted at edge t, and its result is valid after edge t+3.
//
// Ports:
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   cfg_len, exp_bias     group length and right-shift amount, sampled on the
//                         first beat of each group
//   in_valid / in_ready   input beat handshake
//   img, wgt              packed signed lanes; lane i is at [i*W +: W]
//   psum                  signed partial sum, added once per group
//   out_valid / out_ready result handshake
//   out, out_sat          clamped result, and a flag that clamping occurred
//   busy                  a group is partially accepted, or results are in flight
module pe_row_acc #(
    parameter int LANES  = 4,
    parameter int IMG_W  = 8,
    parameter int WGT_W  = 8,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic [4:0]                exp_bias,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*IMG_W-1:0]    img,
    input  logic [LANES*WGT_W-1:0]    wgt,
    input  logic signed [PSUM_W-1:0]  psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out,
    output logic                      out_sat,
    output logic                      busy
);

    localparam int PROD_W = IMG_W + WGT_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                     stall;
    logic                     accept;
    logic [LEN_W-1:0]         cnt;
    logic [LEN_W-1:0]         len_hold;
    logic [4:0]               bias_hold;
    logic signed [PSUM_W-1:0] psum_hold;
    logic                     beat_first;
    logic                     beat_last;
    logic [LEN_W-1:0]         len_eff;
    logic [4:0]               bias_eff;
    logic signed [PSUM_W-1:0] psum_eff;

    logic                     s0_valid, s0_first, s0_last;
    logic [LANES*IMG_W-1:0]   s0_img;
    logic [LANES*WGT_W-1:0]   s0_wgt;
    logic signed [PSUM_W-1:0] s0_psum;
    logic [4:0]               s0_bias;

    logic                     s1_valid, s1_first, s1_last;
    logic signed [PROD_W-1:0] s1_prod [LANES];
    logic signed [PROD_W-1:0] prod_c  [LANES];
    logic signed [PSUM_W-1:0] s1_psum;
    logic [4:0]               s1_bias;

    logic                     s2_valid, s2_first, s2_last;
    logic signed [SUM_W-1:0]  s2_sum;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [PSUM_W-1:0] s2_psum;
    logic [4:0]               s2_bias;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  clamped;
    logic                     clamp_hit;

    // A pending result that the consumer refuses freezes the whole row, so
    // nothing in flight can overwrite it.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0) || s0_valid || s1_valid || s2_valid || out_valid;

    // Group configuration comes live from the ports on the first beat and from
    // the held copies afterwards, so mid-group port changes have no effect.
    // psum and bias ride along with each beat because the next group may start
    // sampling new values before this group's last beat reaches S3.
    assign beat_first = (cnt == '0);
    assign len_eff    = beat_first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_hold;
    assign bias_eff   = beat_first ? exp_bias : bias_hold;
    assign psum_eff   = beat_first ? psum : psum_hold;
    assign beat_last  = (cnt == len_eff - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            len_hold  <= LEN_W'(1);
            bias_hold <= '0;
            psum_hold <= '0;
        end else if (accept) begin
            cnt <= beat_last ? '0 : cnt + LEN_W'(1);
            if (beat_first) begin
                len_hold  <= len_eff;
                bias_hold <= exp_bias;
                psum_hold <= psum;
            end
        end
    end

    // S0: capture the accepted beat with its group tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_img   <= '0;
            s0_wgt   <= '0;
            s0_psum  <= '0;
            s0_bias  <= '0;
        end else if (!stall) begin
            s0_valid <= accept;
            s0_first <= beat_first;
            s0_last  <= beat_last;
            s0_img   <= img;
            s0_wgt   <= wgt;
            s0_psum  <= psum_eff;
            s0_bias  <= bias_eff;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = $signed(s0_img[i*IMG_W +: IMG_W]) * $signed(s0_wgt[i*WGT_W +: WGT_W]);
        end
    end

    // S1: registered per-lane signed products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_psum  <= '0;
            s1_bias  <= '0;
            for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
        end else if (!stall) begin
            s1_valid <= s0_valid;
            s1_first <= s0_first;
            s1_last  <= s0_last;
            s1_psum  <= s0_psum;
            s1_bias  <= s0_bias;
            for (int i = 0; i < LANES; i++) s1_prod[i] <= prod_c[i];
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_c = sum_c + SUM_W'(s1_prod[i]);
        end
    end

    // S2: registered lane sum, wide enough that it can never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
            s2_psum  <= '0;
            s2_bias  <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_sum   <= sum_c;
            s2_psum  <= s1_psum;
            s2_bias  <= s1_bias;
        end
    end

    // S3 datapath: the first beat restarts from psum instead of the old acc.
    // The shift is arithmetic, so negative results round toward -inf.
    always_comb begin
        acc_next  = s2_first ? (ACC_W'(s2_sum) + ACC_W'(s2_psum)) : (acc + ACC_W'(s2_sum));
        shifted   = acc_next >>> s2_bias;
        clamped   = shifted;
        clamp_hit = 1'b0;
        if (shifted > OUT_MAX) begin
            clamped   = OUT_MAX;
            clamp_hit = 1'b1;
        end else if (shifted < OUT_MIN) begin
            clamped   = OUT_MIN;
            clamp_hit = 1'b1;
        end
    end

    // S3 registers: the accumulator, plus the output word, which loads on the
    // last beat. A new result may load in the same edge that the previous one
    // is taken, so out_valid stays high across back-to-back results.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out       <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (s2_valid) begin
                acc <= s2_last ? '0 : acc_next;
            end
            if (s2_valid && s2_last) begin
                out       <= clamped[OUT_W-1:0];
                out_sat   <= clamp_hit;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_row_acc.sv
// tb_pe_row_acc
// Directed bench for pe_row_acc with default parameters. Expected results are
// pushed into a scoreboard queue as each group is issued. A separate monitor
// pops and compares on every output handshake.
module tb_pe_row_acc;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         cfg_len;
    logic [4:0]         exp_bias;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        img;
    logic [31:0]        wgt;
    logic signed [15:0] psum;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out;
    logic               out_sat;
    logic               busy;

    typedef struct {
        int value;
        bit sat;
    } expect_t;

    expect_t sbQueue[$];
    int      compared   = 0;
    int      mismatched = 0;

    always #5 clk = ~clk;

    pe_row_acc dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .exp_bias  (exp_bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .img       (img),
        .wgt       (wgt),
        .psum      (psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    // Shared comparison helper: it counts every comparison and reports each failure.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input int value, input bit sat);
        expect_t e;
        e.value = value;
        e.sat   = sat;
        sbQueue.push_back(e);
    endtask

    // Monitor: a handshake occurs at the next rising edge whenever valid and
    // ready are both high at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got %0d, expected no result", out);
            end else begin
                expect_t e;
                e = sbQueue.pop_front();
                checkOutput("out", out, e.value);
                checkOutput("out_sat", out_sat, e.sat);
            end
        end
    end

    // Drives one beat and holds it until it is accepted. The task returns
    // 1 ns after the accepting edge.
    task automatic applyStimulus(input logic signed [7:0] imgLane, input logic signed [7:0] wgtLane,
                                 input logic signed [15:0] psumV, input logic [7:0] len,
                                 input logic [4:0] bias);
        int waited = 0;
        bit took   = 1'b0;
        in_valid = 1'b1;
        img      = {4{imgLane}};
        wgt      = {4{wgtLane}};
        psum     = psumV;
        cfg_len  = len;
        exp_bias = bias;
        while (!took && waited < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!took) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: got no acceptance, expected acceptance within 200 cycles");
        end
    endtask

    // The result must be invisible after edges t..t+2 and visible after t+3.
    task automatic checkLatency(input string tag);
        repeat (3) begin
            @(negedge clk);
            checkOutput({tag, "_early_valid"}, out_valid, 0);
        end
        @(negedge clk);
        checkOutput({tag, "_valid_at_3"}, out_valid, 1);
    endtask

    task automatic drain();
        int w = 0;
        while ((sbQueue.size() != 0 || busy) && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 100) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sbQueue.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        img       = '0;
        wgt       = '0;
        psum      = '0;
        cfg_len   = 8'd1;
        exp_bias  = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out", out, 0);
        checkOutput("reset_out_sat", out_sat, 0);

        $display("[TB] single-beat group");
        pushExpect(435, 0);
        applyStimulus(8'sd15, 8'sd7, 16'sd15, 8'd1, 5'd0);
        checkLatency("t1");
        drain();

        $display("[TB] shift and zero length");
        pushExpect(108, 0);
        applyStimulus(8'sd15, 8'sd7, 16'sd15, 8'd0, 5'd2);
        drain();
        pushExpect(-6, 0);
        applyStimulus(-8'sd3, 8'sd1, 16'sd0, 8'd1, 5'd1);
        drain();

        $display("[TB] multi-beat accumulation");
        pushExpect(-1524, 0);
        applyStimulus(-8'sd1, 8'sd127, 16'sd0, 8'd3, 5'd0);
        applyStimulus(-8'sd1, 8'sd127, 16'sd999, 8'd1, 5'd7);
        applyStimulus(-8'sd1, 8'sd127, -16'sd77, 8'd2, 5'd3);
        checkLatency("t3");
        drain();

        $display("[TB] saturation");
        pushExpect(32767, 1);
        applyStimulus(8'sd127, 8'sd127, 16'sd0, 8'd2, 5'd0);
        applyStimulus(8'sd127, 8'sd127, 16'sd0, 8'd2, 5'd0);
        pushExpect(-32768, 1);
        applyStimulus(-8'sd128, 8'sd127, 16'sd0, 8'd1, 5'd0);
        drain();

        $display("[TB] backpressure");
        fork
            begin
                pushExpect(10, 0);
                applyStimulus(8'sd1, 8'sd2, 16'sd2, 8'd1, 5'd0);
                pushExpect(20, 0);
                applyStimulus(8'sd2, 8'sd2, 16'sd4, 8'd1, 5'd0);
                pushExpect(30, 0);
                applyStimulus(8'sd3, 8'sd2, 16'sd6, 8'd1, 5'd0);
                pushExpect(40, 0);
                applyStimulus(8'sd4, 8'sd2, 16'sd8, 8'd1, 5'd0);
            end
            begin
                int w = 0;
                while (!out_valid && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (!out_valid) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL first_result_timeout: got no result, expected one within 50 cycles");
                end
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] reset mid-group");
        applyStimulus(8'sd5, 8'sd5, 16'sd100, 8'd3, 5'd0);
        applyStimulus(8'sd5, 8'sd5, 16'sd100, 8'd3, 5'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        pushExpect(435, 0);
        applyStimulus(8'sd15, 8'sd7, 16'sd15, 8'd1, 5'd0);
        checkLatency("t6");
        drain();

        checkOutput("scoreboard_empty", sbQueue.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pe_row_acc.md
# pe_row_acc

Parametrised successor to the fixed 4-lane PE row: a LANES-wide signed multiply-accumulate row with a 3-stage pipeline, multi-beat accumulation over a configurable group length, arithmetic right-shift scaling by `exp_bias`, output saturation and a valid/ready handshake on both sides. It sits between the operand feeders and the psum collector in the MAC array. Each group of `cfg_len` input beats yields exactly one output word.

## Interface
- `LANES`, default 4: number of img/wgt lane pairs.
- `IMG_W`, default 8: signed img lane width.
- `WGT_W`, default 8: signed wgt lane width.
- `PSUM_W`, default 16: signed psum input width.
- `ACC_W`, default 32: accumulator width.
- `OUT_W`, default 16: signed output width.
- `LEN_W`, default 8: width of `cfg_len`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_len`  in  LEN_W  beats per group; 0 is treated as 1.
- `exp_bias`  in  5  arithmetic right-shift amount applied to the result.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts the beat.
- `img`  in  LANES*IMG_W  lane i at bits [i*IMG_W +: IMG_W], two's complement.
- `wgt`  in  LANES*WGT_W  lane i at bits [i*WGT_W +: WGT_W], two's complement.
- `psum`  in  PSUM_W  signed partial sum, added once per group.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  OUT_W  scaled, saturated result.
- `out_sat`  out  1  high with `out_valid` if saturation occurred.
- `busy`  out  1  a group is partially accepted or beats are in flight.

## Operation
- Beat accepted when `in_valid && in_ready`.
- Beat counter `cnt` (LEN_W bits) counts accepted beats. First beat: `cnt==0`. On the first beat, `cfg_len`, `exp_bias` and `psum` are sampled and held for the group. Changes to these inputs mid-group are ignored.
- Last beat: `cnt==len_s-1`, where `len_s = max(cfg_len,1)`. After the last beat, `cnt` wraps to 0.
- First/last tags travel down the pipeline with the data.
- S1: per-lane signed products, each IMG_W+WGT_W bits, registered.
- S2: signed sum of the LANES products, registered; width is IMG_W+WGT_W+clog2(LANES).
- S3 accumulate:
  - First beat: `acc = sext(sum) + sext(psum_s)`.
  - Otherwise: `acc = acc + sext(sum)`.
  - Arithmetic is modulo 2^ACC_W.
- S3 on the last beat:
  - Compute `r = acc_next >>> exp_bias_s` (arithmetic shift).
  - Clamp `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and load the clamped value into `out`.
  - Set `out_sat` = (clamping changed the value). Set `out_valid` = 1.
  - Clear `acc` to 0.
- Stall: `stall = out_valid && !out_ready`.
  - While stalled, every stage, `cnt` and `acc` hold, and `in_ready = 0`.
  - Otherwise `in_ready = 1`.
- `out_valid` clears on the handshake (`out_valid && out_ready`) unless a new result loads in the same edge. In that case `out_valid` stays 1 with the new data.
- `busy = (cnt!=0) || any stage valid || out_valid`.
- Reset: `cnt`, all stage valids, `acc`, `out`, `out_sat` and `out_valid` go to 0; `in_ready` = 1 after reset. A partially accumulated group is discarded.

## Timing
- Pipeline latency: 3 edges from the last beat's acceptance edge to `out_valid` high, when unstalled. Example: last beat accepted at edge t, `out_valid` high after edge t+3.
- Throughput: 1 beat/cycle sustained when `out_ready` stays high. `len_s=1` groups give 1 result/cycle.
- Back-to-back groups need no bubble. The first beat of group N+1 may directly follow the last beat of group N.
- `in_ready` is combinational from `out_valid` and `out_ready` only, not from `in_valid`.
- Each stall cycle adds exactly one cycle to all in-flight latencies. No beat is dropped or duplicated.
- `rst` asserted in any cycle overrides the handshake in that cycle. The outputs read the reset values after that edge.

## Test plan
All scenarios use default parameters.
1. Single-beat group: `cfg_len=1`, `exp_bias=0`, all img lanes 15, all wgt lanes 7, `psum=15` -> `out=435`, `out_sat=0`; `out_valid` rises exactly 3 edges after acceptance.
2. Shift and zero length: same operands, `cfg_len=0`, `exp_bias=2` -> `out=108`. With img lanes -3, wgt lanes 1, `psum=0`, `exp_bias=1` -> `out=-6`, the arithmetic shift rounding toward -inf.
3. Multi-beat signed accumulation: `cfg_len=3`, `psum=0`, three beats of img=-1 and wgt=127 on all lanes -> one result, `out=-1524`, 3 edges after the third beat; no output after beats 1 or 2.
4. Saturation: `cfg_len=2`, img=127 and wgt=127 on all lanes -> `out=32767`, `out_sat=1`. With img=-128 and wgt=127, `cfg_len=1` -> `out=-32768`, `out_sat=1`.
5. Backpressure: stream four `len=1` groups with results 10, 20, 30, 40 and hold `out_ready=0` for 5 cycles after the first result -> `in_ready=0` during the stall; results arrive in order 10, 20, 30, 40, each exactly once.
6. Reset mid-group: `cfg_len=3`; accept 2 beats, pulse `rst` for one cycle, then send a `len=1` group (img 15, wgt 7, psum 15) -> `out=435`, uncontaminated by the discarded beats; `busy=0` and `out_valid=0` right after reset.
